pdp8_tt_uart: RTL and testbench
===============================

// Module: pdp8_tt_uart
// PURPOSE
//  Serial line engine beneath the PDP-8 console (TTI/TTO) controller. It sits directly
//  downstream of it: it accepts output characters over a req/ack handshake and shifts
//  them out as 8N1 async frames. It also deserialises 8N1 input frames and offers each
//  character to the console over a second req/ack handshake. Bit timing comes from
//  baud-rate strobes produced by the baud generator in the clk domain.
// PARAMETERS
//  OVERSAMPLE  16  rx_clk strobes per bit time; must be even and >= 8
//  STOP_BITS   1   transmitted stop bits (1 or 2); the receiver always checks one
// PORTS
//  clk         in   1  single system clock; all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  tx_clk      in   1  one-cycle strobe, once per transmit bit time
//  rx_clk      in   1  one-cycle strobe, OVERSAMPLE times per receive bit time
//  tx_req      in   1  console requests transmit of tx_data
//  tx_data     in   8  character to send; valid while tx_req=1
//  tx_ack      out  1  character taken; high until tx_req drops
//  tx_empty    out  1  1 = no character held or shifting
//  rx_req      in   1  console requests the received character
//  rx_ack      out  1  rx_data valid; high until rx_req drops
//  rx_data     out  8  last delivered character; stable until the next delivery
//  rx_empty    out  1  0 = character waiting in the receive holding register
//  rx_overrun  out  1  one-cycle pulse: received char dropped, holding register full
//  rx_in       in   1  async serial input, idle high
//  tx_out      out  1  serial output, idle high
// BEHAVIOUR
//  Reset values: tx_out=1, tx_ack=0, tx_empty=1, rx_ack=0, rx_empty=1, rx_data=0,
//   rx_overrun=0. Reset mid-frame aborts immediately; a partial frame is not resumed.
//  TX handshake:
//   - When tx_req=1, tx_ack=0 and tx_empty=1: latch tx_data; tx_ack<=1; tx_empty<=0.
//     Both outputs change in the same cycle.
//   - When tx_req=0: tx_ack<=0.
//   - A tx_req while tx_empty=0 waits; there is no second buffer.
//  TX FSM (IDLE, START, DATA, STOP), advances only on tx_clk strobes:
//   - IDLE -> START on the first strobe after a load; tx_out=0 for one bit time.
//   - DATA: 8 bits, LSB first, a 3-bit counter; tx_out=data bit.
//   - STOP: tx_out=1 for STOP_BITS bit times.
//   - Return to IDLE on the strobe that ends the last stop bit; tx_empty<=1 in that
//     same cycle.
//   - tx_out is registered, so there is no glitch between bits.
//  RX input: rx_in passes through a 2-flop synchroniser before any use.
//  RX FSM (IDLE, START, DATA, STOP), advances only on rx_clk strobes:
//   - IDLE -> START on a sampled 0; the tick counter clears.
//   - START: recheck at OVERSAMPLE/2 ticks. If still 0, go to DATA; if 1, the event
//     was a glitch: return to IDLE.
//   - DATA: sample every OVERSAMPLE ticks thereafter, 8 bits LSB first into a shift
//     register.
//   - STOP: sample once. If 1 (good frame):
//     . rx_empty=1: the shift register loads the holding register; rx_empty<=0.
//     . rx_empty=0: the character is discarded; rx_overrun pulses for 1 cycle.
//     If 0 (framing error): the character is discarded silently; rx_empty is unchanged.
//   - Return to IDLE after the stop sample, so back-to-back frames are accepted.
//  RX handshake:
//   - When rx_req=1, rx_ack=0 and rx_empty=0: rx_data<=holding register; rx_ack<=1.
//     rx_empty stays 0 while rx_ack=1.
//   - When rx_req=0 and rx_ack=1: rx_ack<=0; rx_empty<=1 in the same cycle.
//   - rx_data holds its value after the handshake so the console can read it late.
//  Simultaneous events:
//   - A good stop bit in the same cycle that rx_ack falls counts as empty: the new
//     character loads and rx_empty stays 0, with no overrun.
//   - TX and RX are fully independent.
// TESTING
//  1 TX: tx_data=8'h41, tx_req=1:
//    - tx_ack=1 and tx_empty=0 on the next edge.
//    - Drop req -> ack=0.
//    - tx_out, one tx_clk period per bit: 0,1,0,0,0,0,0,1,0,1.
//    - tx_empty=1 on the final stop strobe.
//  2 RX: drive an 8'h55 frame, 16 rx_clk ticks per bit:
//    - rx_empty falls after the stop sample.
//    - rx_req -> rx_ack=1 with rx_data=8'h55.
//    - Drop rx_req -> rx_ack=0 and rx_empty=1; rx_data stays 8'h55.
//  3 Glitch: rx_in low for 4 ticks, then high -> no frame; rx_empty stays 1.
//  4 Framing: 8'hA3 frame with stop bit 0 -> rx_empty stays 1; no overrun pulse.
//  5 Overrun: frames 8'h31 then 8'h32 with no rx_req:
//    - rx_overrun pulses once at the second stop sample.
//    - The next handshake returns 8'h31.
//  6 Reset during TX data bit 3 -> next edge tx_out=1, tx_empty=1, tx_ack=0, FSM IDLE.
//    A new tx_req is then accepted normally.

Source files
------------

// File: rtl/pdp8_tt_uart_if.sv
// pdp8_tt_uart_if: console-side handshake bundle for the TT serial line engine
interface pdp8_tt_uart_if;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       tx_empty;
    logic       rx_req;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_overrun;
    modport master (
        output tx_req, tx_data, rx_req,
        input  tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_overrun
    );
    modport slave (
        input  tx_req, tx_data, rx_req,
        output tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_overrun
    );
endinterface

// File: rtl/pdp8_tt_uart.sv
// pdp8_tt_uart: 8N1 serial transmitter/receiver under the PDP-8 console controller
module pdp8_tt_uart #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_clk,
    input  logic               rx_clk,
    input  logic               rx_in,
    output logic               tx_out,
    pdp8_tt_uart_if.slave      bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);

    logic [1:0]    tx_st;
    logic [7:0]    tx_buf;
    logic [2:0]    tx_bit;
    logic          tx_stop;
    logic          rx_s1, rx_s;
    logic [1:0]    rx_st;
    logic [TW-1:0] rx_tick;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_hold;
    logic          rx_good, ack_fall, rx_free;

    // Transmit handshake and frame sequencer; tx_empty is set back only by the last stop strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st        <= IDLE;
            tx_out       <= 1'b1;
            tx_buf       <= 8'h00;
            tx_bit       <= 3'd0;
            tx_stop      <= 1'b0;
            bus.tx_ack   <= 1'b0;
            bus.tx_empty <= 1'b1;
        end else begin
            if (bus.tx_req && !bus.tx_ack && bus.tx_empty) begin
                tx_buf       <= bus.tx_data;
                bus.tx_ack   <= 1'b1;
                bus.tx_empty <= 1'b0;
            end else if (!bus.tx_req) begin
                bus.tx_ack <= 1'b0;
            end
            if (tx_clk) begin
                case (tx_st)
                    IDLE: if (!bus.tx_empty) begin
                        tx_st  <= START;
                        tx_out <= 1'b0;
                    end
                    START: begin
                        tx_st  <= DATA;
                        tx_out <= tx_buf[0];
                        tx_bit <= 3'd0;
                    end
                    DATA: if (tx_bit == 3'd7) begin
                        tx_st   <= STOP;
                        tx_out  <= 1'b1;
                        tx_stop <= 1'b0;
                    end else begin
                        tx_out <= tx_buf[tx_bit + 3'd1];
                        tx_bit <= tx_bit + 3'd1;
                    end
                    default: if (tx_stop == 1'(STOP_BITS - 1)) begin
                        tx_st        <= IDLE;
                        bus.tx_empty <= 1'b1;
                    end else begin
                        tx_stop <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s  <= rx_s1;
        end
    end

    // A falling ack frees the holding register in the same cycle a new stop bit may need it
    assign rx_good  = rx_clk && rx_st == STOP && rx_tick == FULL && rx_s;
    assign ack_fall = !bus.rx_req && bus.rx_ack;
    assign rx_free  = bus.rx_empty || ack_fall;

    // Receive sequencer, holding register and console handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st          <= IDLE;
            rx_tick        <= '0;
            rx_bit         <= 3'd0;
            rx_shift       <= 8'h00;
            rx_hold        <= 8'h00;
            bus.rx_ack     <= 1'b0;
            bus.rx_data    <= 8'h00;
            bus.rx_empty   <= 1'b1;
            bus.rx_overrun <= 1'b0;
        end else begin
            if (rx_clk) begin
                case (rx_st)
                    IDLE: if (!rx_s) begin
                        rx_st   <= START;
                        rx_tick <= '0;
                    end
                    START: if (rx_tick == HALF) begin
                        rx_st   <= rx_s ? IDLE : DATA;
                        rx_tick <= '0;
                        rx_bit  <= 3'd0;
                    end else begin
                        rx_tick <= rx_tick + 1'b1;
                    end
                    DATA: if (rx_tick == FULL) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_tick  <= '0;
                        rx_bit   <= rx_bit + 3'd1;
                        rx_st    <= rx_bit == 3'd7 ? STOP : DATA;
                    end else begin
                        rx_tick <= rx_tick + 1'b1;
                    end
                    default: if (rx_tick == FULL) begin
                        rx_st <= IDLE;
                    end else begin
                        rx_tick <= rx_tick + 1'b1;
                    end
                endcase
            end
            if (rx_good && rx_free) rx_hold <= rx_shift;
            bus.rx_empty   <= (rx_good && rx_free) ? 1'b0 : ack_fall ? 1'b1 : bus.rx_empty;
            bus.rx_overrun <= rx_good && !rx_free;
            if (bus.rx_req && !bus.rx_ack && !bus.rx_empty) begin
                bus.rx_data <= rx_hold;
                bus.rx_ack  <= 1'b1;
            end else if (ack_fall) begin
                bus.rx_ack <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pdp8_tt_uart.sv
// tb_pdp8_tt_uart: directed scoreboard bench for the TT serial line engine
module tb_pdp8_tt_uart;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_clk = 1'b0;
    logic rx_clk = 1'b0;
    logic rx_in = 1'b1;
    logic tx_out;
    int   errors = 0;
    int   checks = 0;
    int   ovr = 0;
    int   ovr0;
    logic [7:0] rx_q[$];
    logic       tx_q[$];

    pdp8_tt_uart_if bus();

    pdp8_tt_uart #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
        .clk(clk),
        .reset(reset),
        .tx_clk(tx_clk),
        .rx_clk(rx_clk),
        .rx_in(rx_in),
        .tx_out(tx_out),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.rx_overrun === 1'b1) ovr++;
    endtask

    task automatic rx_tick();
        rx_clk = 1'b1;
        cyc();
        rx_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic tx_tick();
        tx_clk = 1'b1;
        cyc();
        tx_clk = 1'b0;
        cyc();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = f[i];
            repeat (16) rx_tick();
        end
        rx_in = 1'b1;
        repeat (20) rx_tick();
    endtask

    task automatic tx_load(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_req = 1'b1;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
        tx_q.push_back(1'b1);
        cyc();
        chk("tx_ack_rise", 8'(bus.tx_ack), 8'h1);
        chk("tx_empty_load", 8'(bus.tx_empty), 8'h0);
        bus.tx_req = 1'b0;
        cyc();
        chk("tx_ack_fall", 8'(bus.tx_ack), 8'h0);
    endtask

    task automatic tx_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            tx_tick();
            b = tx_q.size() > 0 ? tx_q.pop_front() : 1'bx;
            chk($sformatf("tx_bit%0d", i), 8'(tx_out), 8'(b));
        end
    endtask

    task automatic rx_read();
        logic [7:0] exp;
        bus.rx_req = 1'b1;
        for (int n = 0; n < 20 && bus.rx_ack !== 1'b1; n++) cyc();
        chk("rx_ack_rise", 8'(bus.rx_ack), 8'h1);
        exp = rx_q.size() > 0 ? rx_q.pop_front() : 8'hxx;
        chk("rx_data", bus.rx_data, exp);
        chk("rx_empty_held", 8'(bus.rx_empty), 8'h0);
        bus.rx_req = 1'b0;
        cyc();
        chk("rx_ack_fall", 8'(bus.rx_ack), 8'h0);
        chk("rx_empty_free", 8'(bus.rx_empty), 8'h1);
        chk("rx_data_hold", bus.rx_data, exp);
    endtask

    initial begin
        bus.tx_req = 1'b0;
        bus.tx_data = 8'h00;
        bus.rx_req = 1'b0;
        repeat (3) cyc();
        chk("rst_tx_out", 8'(tx_out), 8'h1);
        chk("rst_tx_ack", 8'(bus.tx_ack), 8'h0);
        chk("rst_tx_empty", 8'(bus.tx_empty), 8'h1);
        chk("rst_rx_ack", 8'(bus.rx_ack), 8'h0);
        chk("rst_rx_empty", 8'(bus.rx_empty), 8'h1);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_overrun", 8'(bus.rx_overrun), 8'h0);
        reset = 1'b0;
        cyc();

        tx_load(8'h41);
        tx_bits(10);
        chk("tx_empty_in_stop", 8'(bus.tx_empty), 8'h0);
        tx_tick();
        chk("tx_empty_end", 8'(bus.tx_empty), 8'h1);
        chk("tx_idle_out", 8'(tx_out), 8'h1);

        rx_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        chk("rx_empty_after_55", 8'(bus.rx_empty), 8'h0);
        rx_read();

        rx_in = 1'b0;
        repeat (4) rx_tick();
        rx_in = 1'b1;
        repeat (20) rx_tick();
        chk("glitch_empty", 8'(bus.rx_empty), 8'h1);

        ovr0 = ovr;
        send_frame(8'hA3, 1'b0);
        chk("framing_empty", 8'(bus.rx_empty), 8'h1);
        chk("framing_no_overrun", 8'(ovr - ovr0), 8'h0);

        ovr0 = ovr;
        rx_q.push_back(8'h31);
        send_frame(8'h31, 1'b1);
        chk("ovr_first_no_pulse", 8'(ovr - ovr0), 8'h0);
        send_frame(8'h32, 1'b1);
        chk("ovr_one_pulse", 8'(ovr - ovr0), 8'h1);
        chk("ovr_still_full", 8'(bus.rx_empty), 8'h0);
        rx_read();

        rx_q.push_back(8'hC6);
        send_frame(8'hC6, 1'b1);
        rx_read();

        tx_load(8'h35);
        tx_bits(5);
        reset = 1'b1;
        cyc();
        chk("rst_mid_tx_out", 8'(tx_out), 8'h1);
        chk("rst_mid_tx_empty", 8'(bus.tx_empty), 8'h1);
        chk("rst_mid_tx_ack", 8'(bus.tx_ack), 8'h0);
        reset = 1'b0;
        tx_q.delete();
        cyc();
        tx_tick();
        chk("rst_idle_out", 8'(tx_out), 8'h1);
        chk("rst_idle_empty", 8'(bus.tx_empty), 8'h1);
        tx_load(8'h96);
        tx_bits(10);
        tx_tick();
        chk("tx2_empty_end", 8'(bus.tx_empty), 8'h1);
        chk("rx_q_drained", 8'(rx_q.size()), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
